// File: rtl/sumdif_pkg.sv
// Shared types and constants for the sum/difference serial decoder.
package sumdif_pkg;

  localparam int W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter must hold 0..W.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit serial full adder (S+D) and full subtractor (S-D) sharing the
// input bits. Bit 0 of a frame seeds carry/borrow through load.
module serial_addsub_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  input  logic s,
  input  logic d,
  output logic sum_bit,
  output logic diff_bit
);

  logic carry, borrow;

  assign sum_bit  = s ^ d ^ carry;
  assign diff_bit = s ^ d ^ borrow;

  // Carry/borrow flops: seed on bit 0, ripple on every later accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else if (load) begin
      carry  <= s & d;
      borrow <= ~s & d;
    end else if (step) begin
      carry  <= (s & d) | (s & carry) | (d & carry);
      borrow <= (~s & d) | (~s & borrow) | (d & borrow);
    end
  end

endmodule

// File: rtl/sumdif_serial_decoder.sv
// Bit-serial decoder: recovers A=(S+D)/2 and B=(S-D)/2 from LSB-first S/D
// frames of W+1 bits. Results appear one cycle after the last accepted bit.
// W must be at least 3.
module sumdif_serial_decoder
  import sumdif_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sof,
  input  logic         bit_valid,
  input  logic         s_bit,
  input  logic         d_bit,
  output logic         busy,
  output logic         out_valid,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic         parity_err
);

  localparam int CW = cnt_w(W);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          load, step, last;
  logic          sum_bit, diff_bit, perr;
  // Bits A[0..W-2] / B[0..W-2]; the top bit comes straight from the cell.
  logic [W-2:0]  a_sr, b_sr;

  serial_addsub_cell u_cell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .s        (s_bit),
    .d        (d_bit),
    .sum_bit  (sum_bit),
    .diff_bit (diff_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and strobes; sof always restarts a frame, even mid-frame.
  always_comb begin
    state_nxt = state;
    load      = bit_valid & sof;
    step      = bit_valid & ~sof & (state == SHIFT);
    last      = step & (cnt == CW'(W));
    if (load)      state_nxt = SHIFT;
    else if (last) state_nxt = IDLE;
  end

  assign busy = (state == SHIFT);

  // Bit counter, parity capture and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      perr <= 1'b0;
      a_sr <= '0;
      b_sr <= '0;
    end else if (load) begin
      cnt  <= CW'(1);
      perr <= s_bit ^ d_bit;
    end else if (step) begin
      cnt  <= cnt + CW'(1);
      a_sr <= {sum_bit, a_sr[W-2:1]};
      b_sr <= {diff_bit, b_sr[W-2:1]};
    end
  end

  // Output registers: load on the last bit, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      parity_err <= 1'b0;
    end else begin
      out_valid <= last;
      if (last) begin
        a_out      <= {sum_bit, a_sr};
        b_out      <= {diff_bit, b_sr};
        parity_err <= perr;
      end
    end
  end

endmodule

// File: tb/tb_sumdif_serial_decoder.sv
// Self-checking bench for sumdif_serial_decoder (W=8).
module tb_sumdif_serial_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sof = 1'b0, bit_valid = 1'b0, s_bit = 1'b0, d_bit = 1'b0;
  logic         busy, out_valid, parity_err;
  logic [W-1:0] a_out, b_out;

  sumdif_serial_decoder #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sof        (sof),
    .bit_valid  (bit_valid),
    .s_bit      (s_bit),
    .d_bit      (d_bit),
    .busy       (busy),
    .out_valid  (out_valid),
    .a_out      (a_out),
    .b_out      (b_out),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nfail = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic         p;
    int           cyc;
  } exp_t;
  exp_t q[$];
  exp_t em;

  typedef struct {
    logic [W:0]   s, d;
    logic [W-1:0] a, b;
    logic         p;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on the whole words.
  function automatic void model(input int s, input int d,
                                output logic [W-1:0] a, output logic [W-1:0] b,
                                output logic p);
    int m;
    m = 1 << (W + 1);
    a = W'((((s + d) % m + m) % m) >> 1);
    b = W'((((s - d) % m + m) % m) >> 1);
    p = 1'((s ^ d) & 1);
  endfunction

  // Output monitor: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL spurious_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          em = q.pop_front();
          chk("a_out", int'(a_out), int'(em.a));
          chk("b_out", int'(b_out), int'(em.b));
          chk("parity_err", int'(parity_err), int'(em.p));
          chk("valid_cycle", cyc, em.cyc);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        em = q.pop_front();
        nvec++; nfail++;
        $display("FAIL missing_valid: got out_valid=0 expected pulse at cycle %0d", em.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0; sof = 1'b0;
      s_bit = 1'($urandom); d_bit = 1'($urandom);
    end
  endtask

  // Send nbits of a frame (bit 0 carries sof); expectation queued on bit W.
  task automatic send(input logic [W:0] s, input logic [W:0] d, input int nbits,
                      input bit stall, input logic [W-1:0] ea,
                      input logic [W-1:0] eb, input logic ep);
    for (int i = 0; i < nbits; i++) begin
      if (stall)
        for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) begin
          @(negedge clk);
          bit_valid = 1'b0; sof = 1'($urandom);
          s_bit = 1'($urandom); d_bit = 1'($urandom);
        end
      @(negedge clk);
      bit_valid = 1'b1; sof = (i == 0);
      s_bit = s[i]; d_bit = d[i];
      if (i == W) q.push_back('{ea, eb, ep, cyc + 1});
    end
  endtask

  task automatic send_model(input logic [W:0] s, input logic [W:0] d, input bit stall);
    logic [W-1:0] a, b;
    logic p;
    model(int'(s), int'(d), a, b, p);
    send(s, d, W + 1, stall, a, b, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{9'h096, 9'h01E, 8'h5A, 8'h3C, 1'b0};
    tbl[1] = '{9'h040, 9'h1E0, 8'h10, 8'h30, 1'b0};
    tbl[2] = '{9'h1FE, 9'h000, 8'hFF, 8'hFF, 1'b0};
    tbl[3] = '{9'h003, 9'h000, 8'h01, 8'h01, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_a_out", int'(a_out), 0);
    chk("rst_b_out", int'(b_out), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    rst_n = 1'b1;
    idle(2);

    // Non-sof bits in IDLE are ignored
    repeat (4) begin
      @(negedge clk);
      bit_valid = 1'b1; sof = 1'b0; s_bit = 1'($urandom); d_bit = 1'($urandom);
    end
    chk("idle_ignores_bits", int'(busy), 0);

    // Spec vectors, no stalls
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].s, tbl[i].d, W + 1, 1'b0, tbl[i].a, tbl[i].b, tbl[i].p);
      idle(2);
    end

    // Negative difference with random stalls
    send(tbl[1].s, tbl[1].d, W + 1, 1'b1, tbl[1].a, tbl[1].b, tbl[1].p);
    idle(2);

    // Back-to-back: second sof lands in the out_valid cycle
    send(tbl[0].s, tbl[0].d, W + 1, 1'b0, tbl[0].a, tbl[0].b, tbl[0].p);
    send(tbl[1].s, tbl[1].d, W + 1, 1'b0, tbl[1].a, tbl[1].b, tbl[1].p);
    @(negedge clk);
    chk("b2b_busy_in_valid_cycle", int'(busy), 0);
    idle(2);

    // Abort: sof reasserted at bit 4, then a full frame
    send(9'h1A5, 9'h0C3, 4, 1'b0, '0, '0, 1'b0);
    chk("busy_mid_frame", int'(busy), 1);
    send(tbl[0].s, tbl[0].d, W + 1, 1'b0, tbl[0].a, tbl[0].b, tbl[0].p);
    idle(2);

    // Async reset at bit 5 of a frame
    send(tbl[2].s, tbl[2].d, 5, 1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_a_out", int'(a_out), 0);
    chk("arst_b_out", int'(b_out), 0);
    bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      bit_valid = 1'b1; sof = 1'b0; s_bit = 1'($urandom); d_bit = 1'($urandom);
    end
    chk("post_rst_idle", int'(busy), 0);
    send(tbl[3].s, tbl[3].d, W + 1, 1'b0, tbl[3].a, tbl[3].b, tbl[3].p);
    idle(2);

    // Random frames against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      logic [W:0] s, d;
      s = (W + 1)'($urandom_range(0, (1 << (W + 1)) - 1));
      d = (W + 1)'($urandom_range(0, (1 << (W + 1)) - 1));
      if ($urandom_range(0, 4) == 0)
        send(s ^ 9'h0F0, d, $urandom_range(1, W), 1'b1, '0, '0, 1'b0);
      send_model(s, d, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);

    chk("pending_expectations", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
